// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes an asynchronous PWM line, measures high time and period
// per cycle, decodes an 8-bit duty code and flags stuck lines or off-nominal periods.
module pwm_capture #(
    parameter int CNT_W      = 16,
    parameter int NOM_PERIOD = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [7:0]       duty,
    output logic             meas_valid,
    output logic             period_err,
    output logic             stuck_low,
    output logic             stuck_high
);

    typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] NOM_CNT    = CNT_W'(NOM_PERIOD);
    localparam logic [CNT_W-1:0] DUTY_MAX   = CNT_W'(255);

    state_t           state_reg;
    logic             sync1_reg;
    logic             pwm_s_reg;
    logic             pwm_d_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [1:0]       warm_reg;
    logic [CNT_W-1:0] per_acc_reg;
    logic [CNT_W-1:0] hi_acc_reg;
    logic [CNT_W-1:0] idle_reg;

    // Edges are masked until the pipeline holds only post-reset samples, so a line
    // that is already high at reset release is not mistaken for a rising edge.
    logic primed;
    logic timeout;
    assign primed  = (warm_reg == 2'd3);
    assign timeout = ~rise_reg & ~fall_reg & (idle_reg == TIMEOUT_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            sync1_reg   <= 1'b0;
            pwm_s_reg   <= 1'b0;
            pwm_d_reg   <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            warm_reg    <= 2'd0;
            per_acc_reg <= '0;
            hi_acc_reg  <= '0;
            idle_reg    <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty        <= 8'd0;
            meas_valid  <= 1'b0;
            period_err  <= 1'b0;
            stuck_low   <= 1'b0;
            stuck_high  <= 1'b0;
        end else begin
            sync1_reg  <= pwm_in;
            pwm_s_reg  <= sync1_reg;
            pwm_d_reg  <= pwm_s_reg;
            rise_reg   <= primed & pwm_s_reg & ~pwm_d_reg;
            fall_reg   <= primed & ~pwm_s_reg & pwm_d_reg;
            meas_valid <= 1'b0;
            if (!primed)
                warm_reg <= warm_reg + 2'd1;

            // pwm_d_reg is the line level aligned with rise_reg/fall_reg.
            if (rise_reg) begin
                per_acc_reg <= CNT_ONE;
                hi_acc_reg  <= CNT_ONE;
            end else begin
                if (per_acc_reg != CNT_MAX)
                    per_acc_reg <= per_acc_reg + CNT_ONE;
                if (pwm_d_reg && hi_acc_reg != CNT_MAX)
                    hi_acc_reg <= hi_acc_reg + CNT_ONE;
            end

            if (rise_reg || fall_reg)
                idle_reg <= '0;
            else if (state_reg != STUCK && idle_reg != CNT_MAX)
                idle_reg <= idle_reg + CNT_ONE;

            case (state_reg)
                IDLE, MEASURE: begin
                    if (rise_reg) begin
                        state_reg  <= MEASURE;
                        stuck_low  <= 1'b0;
                        stuck_high <= 1'b0;
                        if (state_reg == MEASURE) begin
                            period_cnt <= per_acc_reg;
                            high_cnt   <= hi_acc_reg;
                            duty       <= (hi_acc_reg > DUTY_MAX) ? 8'hFF : hi_acc_reg[7:0];
                            period_err <= (per_acc_reg != NOM_CNT);
                            meas_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        state_reg  <= STUCK;
                        stuck_low  <= ~pwm_d_reg;
                        stuck_high <= pwm_d_reg;
                        duty       <= pwm_d_reg ? 8'hFF : 8'h00;
                        meas_valid <= 1'b1;
                    end
                end
                STUCK: begin
                    if (rise_reg) begin
                        state_reg  <= MEASURE;
                        stuck_low  <= 1'b0;
                        stuck_high <= 1'b0;
                    end else if (fall_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed/randomized bench for pwm_capture: a waveform-level model predicts every
// completed-period report and every stuck-line pulse.
module tb_pwm_capture;
    localparam int CNT_W = 16;
    localparam int NOM   = 256;
    localparam int TO    = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [7:0]       duty;
    logic             meas_valid;
    logic             period_err;
    logic             stuck_low;
    logic             stuck_high;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .NOM_PERIOD(NOM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .duty(duty),
        .meas_valid(meas_valid), .period_err(period_err),
        .stuck_low(stuck_low), .stuck_high(stuck_high)
    );

    typedef struct {int due; int hi; int per;} rep_t;
    rep_t exp_q[$];

    int n_cmp = 0, n_err = 0, cyc = 0;
    bit armed = 1'b0;
    int prev_rise = 0, hi_since = 0, last_edge = 0;
    int last_hi = 0, last_per = 0;
    int win_lo = -1, win_hi = -1;
    bit exp_stuck_high = 1'b0;
    int stuck_pulses = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        rep_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid === 1'b1 && (stuck_low === 1'b1 || stuck_high === 1'b1)) begin
            stuck_pulses++;
            chk("stuck_in_window", 32'(cyc >= win_lo && cyc <= win_hi), 1);
            chk("stuck_high_flag", 32'(stuck_high), 32'(exp_stuck_high));
            chk("stuck_low_flag", 32'(stuck_low), 32'(!exp_stuck_high));
            chk("stuck_duty", 32'(duty), exp_stuck_high ? 255 : 0);
            chk("stuck_high_cnt_hold", 32'(high_cnt), last_hi);
            chk("stuck_period_cnt_hold", 32'(period_cnt), last_per);
            win_lo = -1;
            win_hi = -1;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            $display("report @%0d: hi=%0d per=%0d duty=%0d err=%0d", cyc, high_cnt, period_cnt, duty, period_err);
            chk("meas_valid_due", 32'(meas_valid), 1);
            chk("high_cnt", 32'(high_cnt), r.hi);
            chk("period_cnt", 32'(period_cnt), r.per);
            chk("duty", 32'(duty), (r.hi > 255) ? 255 : r.hi);
            chk("period_err", 32'(period_err), 32'(r.per != NOM));
            last_hi  = r.hi;
            last_per = r.per;
        end else begin
            chk("no_unexpected_valid", 32'(meas_valid), 0);
        end
    endtask

    // Drive one cycle of the line; a rising edge closes the previous period.
    task automatic drive(bit b);
        rep_t r;
        if (b && !pwm_in) begin
            if (armed) begin
                r.due = cyc + 4;
                r.hi  = hi_since;
                r.per = cyc - prev_rise;
                exp_q.push_back(r);
            end
            armed     = 1'b1;
            prev_rise = cyc;
            hi_since  = 0;
        end
        if (b != pwm_in) last_edge = cyc;
        pwm_in = b;
        if (b) hi_since++;
        tick();
    endtask

    task automatic run(int hi, int per, int n);
        repeat (n) for (int i = 0; i < per; i++) drive(i < hi);
    endtask

    task automatic hold(bit b, int n);
        repeat (n) drive(b);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_high_cnt"}, 32'(high_cnt), 0);
        chk({tag, "_period_cnt"}, 32'(period_cnt), 0);
        chk({tag, "_duty"}, 32'(duty), 0);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 0);
        chk({tag, "_period_err"}, 32'(period_err), 0);
        chk({tag, "_stuck_low"}, 32'(stuck_low), 0);
        chk({tag, "_stuck_high"}, 32'(stuck_high), 0);
    endtask

    initial begin
        int per, hi;
        repeat (3) tick();
        chk_zero("reset");

        // Line low from reset: one stuck-low pulse about TIMEOUT cycles after reset.
        rst = 1'b0;
        win_lo = cyc + TO - 4;
        win_hi = cyc + TO + 8;
        exp_stuck_high = 1'b0;
        hold(1'b0, 1100);
        chk("stuck_low_set", 32'(stuck_low), 1);
        chk("stuck_pulses_1", stuck_pulses, 1);

        // Recovery without a report for the aborted period, then steady duty 64.
        run(64, 256, 6);
        chk("stuck_low_cleared", 32'(stuck_low), 0);

        // Mid-run duty changes and an off-nominal period.
        run(128, 256, 4);
        run(192, 256, 4);
        run(50, 200, 4);

        // Line forced high after a rise.
        run(64, 256, 2);
        win_lo = cyc + TO - 4;
        win_hi = cyc + TO + 8;
        exp_stuck_high = 1'b1;
        hold(1'b1, 1200);
        armed = 1'b0;
        chk("stuck_high_set", 32'(stuck_high), 1);
        chk("stuck_pulses_2", stuck_pulses, 2);
        hold(1'b0, 100);
        chk("stuck_high_held_after_fall", 32'(stuck_high), 1);
        run(64, 256, 3);
        chk("stuck_high_cleared", 32'(stuck_high), 0);

        // Randomized periods and high times, plus a saturating duty.
        for (int k = 0; k < 12; k++) begin
            per = int'($urandom_range(40, 320));
            hi  = int'($urandom_range(1, per - 1));
            run(hi, per, 2);
        end
        run(290, 300, 2);

        // Reset pulse during a high phase discards the partial measurement.
        run(64, 256, 2);
        hold(1'b1, 20);
        rst = 1'b1;
        exp_q.delete();
        armed = 1'b0;
        tick();
        chk_zero("midreset");
        rst = 1'b0;
        hold(1'b1, 44);
        hold(1'b0, 192);
        run(64, 256, 3);
        hold(1'b0, 10);

        chk("queue_drained", exp_q.size(), 0);
        chk("stuck_pulses_total", stuck_pulses, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
